crossbar_sched: RTL and testbench

//  Scheduler and front end for the N-to-N crossbar. It takes one request per input lane, each

---
 rtl/crossbar_sched_if.sv | 31 +++
 rtl/crossbar_sched.sv | 101 ++++++++++
 tb/tb_crossbar_sched.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/crossbar_sched_if.sv
// Request/response bundle between the producer lanes, the scheduler and the crossbar.
interface crossbar_sched_if #(
  parameter int unsigned N       = 8,
  parameter int unsigned DW_DATA = 32,
  parameter int unsigned DW_IDX  = $clog2(N) + 1,
  parameter int unsigned DW_CNT  = 32
);
  localparam int unsigned PW = $clog2(N);

  logic [N-1:0]         req_valid;
  logic [N*PW-1:0]      req_dest;
  logic [N*DW_DATA-1:0] req_data;
  logic [N-1:0]         req_ready;
  logic [N-1:0]         out_ready;
  logic [N*DW_IDX-1:0]  xbar_idx;
  logic [N*DW_DATA-1:0] xbar_in;
  logic [N-1:0]         out_valid;
  logic [DW_CNT-1:0]    stall_cnt;

  // Producer / consumer side
  modport master (
    output req_valid, req_dest, req_data, out_ready,
    input  req_ready, xbar_idx, xbar_in, out_valid, stall_cnt
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_dest, req_data, out_ready,
    output req_ready, xbar_idx, xbar_in, out_valid, stall_cnt
  );
endinterface

// File: rtl/crossbar_sched.sv
// Round-robin scheduler and front end for an N-to-N crossbar with registered control.
module crossbar_sched #(
  parameter int unsigned N       = 8,
  parameter int unsigned DW_DATA = 32,
  parameter int unsigned DW_IDX  = $clog2(N) + 1,
  parameter int unsigned DW_CNT  = 32
) (
  input logic             clk,
  input logic             rst,
  crossbar_sched_if.slave bus
);
  localparam int unsigned PW = $clog2(N);
  localparam logic [DW_IDX-1:0] PARK = DW_IDX'(N);

  logic [N-1:0][PW-1:0]      dest;
  logic [N-1:0][DW_DATA-1:0] data;

  logic [N-1:0][PW-1:0]      ptr_q, ptr_d;
  logic [N-1:0]              out_win;
  logic [N-1:0]              grant;
  logic [PW-1:0]             lane;
  int unsigned               sum;

  logic [N-1:0][DW_IDX-1:0]  idx_d, idx_q;
  logic [N-1:0][DW_DATA-1:0] data_s1_d, data_s1_q;
  logic [N-1:0]              valid_s1_q;
  logic [N-1:0][DW_DATA-1:0] xin_q;
  logic [N-1:0]              out_valid_q;
  logic [DW_CNT-1:0]         stall_q;
  logic                      stall_any;

  assign dest = bus.req_dest;
  assign data = bus.req_data;

  // Per-output round-robin: first candidate at or after ptr[j], wrapping modulo N
  always_comb begin
    ptr_d   = ptr_q;
    out_win = '0;
    grant   = '0;
    lane    = '0;
    sum     = 0;
    for (int unsigned j = 0; j < N; j++) begin
      for (int unsigned k = 0; k < N; k++) begin
        sum = 32'(ptr_q[j]) + k;
        if (sum >= N) sum = sum - N;
        lane = PW'(sum);
        if (!out_win[j] && bus.out_ready[j] && bus.req_valid[lane] &&
            dest[lane] == PW'(j)) begin
          out_win[j]  = 1'b1;
          grant[lane] = 1'b1;
          ptr_d[j]    = (sum + 1 == N) ? '0 : PW'(sum + 1);
        end
      end
    end
  end

  // Stage-1 inputs: winners forward dest/data, everyone else parks
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      idx_d[i]     = grant[i] ? DW_IDX'(dest[i]) : PARK;
      data_s1_d[i] = grant[i] ? data[i] : '0;
    end
  end

  // Pointers and the two-stage pipeline; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      idx_q       <= {N{PARK}};
      data_s1_q   <= '0;
      valid_s1_q  <= '0;
      xin_q       <= '0;
      out_valid_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      data_s1_q   <= data_s1_d;
      valid_s1_q  <= out_win;
      // Data lags idx by one edge because the crossbar registers idx internally
      xin_q       <= data_s1_q;
      out_valid_q <= valid_s1_q;
    end
  end

  assign stall_any = |(bus.req_valid & ~grant);

  // Saturating count of cycles with at least one waiting lane
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (stall_any && stall_q != '1) begin
      stall_q <= stall_q + DW_CNT'(1);
    end
  end

  assign bus.req_ready = grant;
  assign bus.xbar_idx  = idx_q;
  assign bus.xbar_in   = xin_q;
  assign bus.out_valid = out_valid_q;
  assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_crossbar_sched.sv
// Directed bench for crossbar_sched with N=4, including a behavioural crossbar model.
module tb_crossbar_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  crossbar_sched_if #(.N(4), .DW_DATA(32), .DW_IDX(3), .DW_CNT(32)) bus ();

  crossbar_sched #(.N(4), .DW_DATA(32), .DW_IDX(3), .DW_CNT(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Crossbar model: registered idx per input lane, combinational data path
  logic [3:0][2:0]  ctrl_q;
  logic [3:0][31:0] xin;
  logic [3:0][31:0] xout;
  assign xin = bus.xbar_in;
  always @(posedge clk) ctrl_q <= bus.xbar_idx;
  always_comb begin
    xout = '0;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++)
        if (ctrl_q[i] == 3'(j)) xout[j] = xout[j] | xin[i];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      bus.req_valid = 4'($urandom);
      bus.req_dest  = 8'($urandom);
      bus.req_data  = {$urandom, $urandom, $urandom, $urandom};
      bus.out_ready = 4'($urandom);
      tick();
    end
    rst = 1'b0;
    bus.req_valid = '0;
    #1;
    nvec++; if (bus.req_ready !== 4'b0000) begin nerr++;
      $display("FAIL reset_ready got %b want 0000", bus.req_ready); end
    nvec++; if (bus.xbar_idx !== {4{3'd4}}) begin nerr++;
      $display("FAIL reset_idx got %h want %h", bus.xbar_idx, {4{3'd4}}); end
    nvec++; if (bus.out_valid !== 4'b0000) begin nerr++;
      $display("FAIL reset_out_valid got %b want 0000", bus.out_valid); end
    nvec++; if (bus.stall_cnt !== 32'd0) begin nerr++;
      $display("FAIL reset_stall got %0d want 0", bus.stall_cnt); end
    nvec++; if (bus.xbar_in !== 128'd0) begin nerr++;
      $display("FAIL reset_xbar_in got %h want 0", bus.xbar_in); end
    tick();
  endtask

  task automatic test_permutation();
    logic [3:0][31:0] exp_out;
    do_reset();
    exp_out = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000, 32'hA000_0003};
    bus.req_valid = 4'hF;
    bus.req_dest  = {2'd0, 2'd3, 2'd2, 2'd1};
    bus.req_data  = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    bus.out_ready = 4'hF;
    #1;
    nvec++; if (bus.req_ready !== 4'hF) begin nerr++;
      $display("FAIL perm_ready got %b want 1111", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    #1;
    nvec++; if (bus.xbar_idx !== {3'd0, 3'd3, 3'd2, 3'd1}) begin nerr++;
      $display("FAIL perm_idx got %h want %h", bus.xbar_idx, {3'd0, 3'd3, 3'd2, 3'd1}); end
    nvec++; if (bus.out_valid !== 4'h0) begin nerr++;
      $display("FAIL perm_valid_early got %b want 0000", bus.out_valid); end
    tick();
    #1;
    nvec++; if (bus.out_valid !== 4'hF) begin nerr++;
      $display("FAIL perm_out_valid got %b want 1111", bus.out_valid); end
    for (int j = 0; j < 4; j++) begin
      nvec++; if (xout[j] !== exp_out[j]) begin nerr++;
        $display("FAIL perm_out%0d got %h want %h", j, xout[j], exp_out[j]); end
    end
    nvec++; if (bus.xbar_idx !== {4{3'd4}}) begin nerr++;
      $display("FAIL perm_idx_park got %h want %h", bus.xbar_idx, {4{3'd4}}); end
    nvec++; if (bus.stall_cnt !== 32'd0) begin nerr++;
      $display("FAIL perm_stall got %0d want 0", bus.stall_cnt); end
    tick();
  endtask

  task automatic test_hotspot();
    logic [31:0] exp_d;
    do_reset();
    bus.req_valid = 4'hF;
    bus.req_dest  = {4{2'd2}};
    bus.req_data  = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000};
    bus.out_ready = 4'hF;
    for (int c = 0; c < 6; c++) begin
      #1;
      nvec++; if (bus.req_ready !== 4'(1 << (c % 4))) begin nerr++;
        $display("FAIL hot_grant c%0d got %b want %b", c, bus.req_ready, 4'(1 << (c % 4))); end
      nvec++; if (bus.stall_cnt !== 32'(c)) begin nerr++;
        $display("FAIL hot_stall c%0d got %0d want %0d", c, bus.stall_cnt, c); end
      nvec++; if (bus.out_valid !== ((c >= 2) ? 4'b0100 : 4'b0000)) begin nerr++;
        $display("FAIL hot_valid c%0d got %b", c, bus.out_valid); end
      if (c >= 2) begin
        exp_d = 32'hB000_0000 + 32'((c - 2) % 4);
        nvec++; if (xout[2] !== exp_d) begin nerr++;
          $display("FAIL hot_data c%0d got %h want %h", c, xout[2], exp_d); end
      end
      tick();
    end
    bus.req_valid = '0;
  endtask

  task automatic test_fairness();
    do_reset();
    bus.out_ready = 4'hF;
    bus.req_dest  = {2'd0, 2'd1, 2'd0, 2'd1};
    bus.req_data  = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    bus.req_valid = 4'b0010;
    #1;
    nvec++; if (bus.req_ready !== 4'b0010) begin nerr++;
      $display("FAIL fair_first got %b want 0010", bus.req_ready); end
    tick();
    bus.req_valid = 4'b1010;
    #1;
    nvec++; if (bus.req_ready !== 4'b1000) begin nerr++;
      $display("FAIL fair_lane3 got %b want 1000", bus.req_ready); end
    tick();
    #1;
    nvec++; if (bus.req_ready !== 4'b0010) begin nerr++;
      $display("FAIL fair_lane1 got %b want 0010", bus.req_ready); end
    tick();
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_dest  = {2'd0, 2'd0, 2'd0, 2'd1};
    bus.out_ready = 4'hF;
    bus.req_data  = {96'd0, 32'hD000_0000};
    #1;
    nvec++; if (bus.req_ready !== 4'b0001) begin nerr++;
      $display("FAIL bp_grant0 got %b want 0001", bus.req_ready); end
    tick();
    bus.req_data = {96'd0, 32'hD000_0001};
    #1;
    nvec++; if (bus.req_ready !== 4'b0001) begin nerr++;
      $display("FAIL bp_grant1 got %b want 0001", bus.req_ready); end
    tick();
    bus.req_data  = {96'd0, 32'hD000_0002};
    bus.out_ready = 4'b1101;
    for (int c = 0; c < 2; c++) begin
      #1;
      nvec++; if (bus.req_ready !== 4'b0000) begin nerr++;
        $display("FAIL bp_blocked c%0d got %b want 0000", c, bus.req_ready); end
      nvec++; if (bus.out_valid !== 4'b0010) begin nerr++;
        $display("FAIL bp_inflight_valid c%0d got %b want 0010", c, bus.out_valid); end
      nvec++; if (xout[1] !== 32'hD000_0000 + 32'(c)) begin nerr++;
        $display("FAIL bp_inflight_data c%0d got %h want %h", c, xout[1],
                 32'hD000_0000 + 32'(c)); end
      tick();
    end
    bus.out_ready = 4'hF;
    #1;
    nvec++; if (bus.req_ready !== 4'b0001) begin nerr++;
      $display("FAIL bp_regrant got %b want 0001", bus.req_ready); end
    nvec++; if (bus.out_valid !== 4'b0000) begin nerr++;
      $display("FAIL bp_drained got %b want 0000", bus.out_valid); end
    nvec++; if (bus.stall_cnt !== 32'd2) begin nerr++;
      $display("FAIL bp_stall got %0d want 2", bus.stall_cnt); end
    tick();
    bus.req_valid = '0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus.out_ready = 4'hF;
    bus.req_valid = 4'b0001;
    bus.req_dest  = {2'd3, 2'd3, 2'd3, 2'd3};
    bus.req_data  = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
    #1;
    nvec++; if (bus.req_ready !== 4'b0001) begin nerr++;
      $display("FAIL mid_grant got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      nvec++; if (bus.out_valid !== 4'b0000) begin nerr++;
        $display("FAIL mid_dropped c%0d got %b want 0000", c, bus.out_valid); end
      tick();
    end
    bus.req_valid = 4'b0101;
    #1;
    nvec++; if (bus.req_ready !== 4'b0001) begin nerr++;
      $display("FAIL mid_ptr_reset got %b want 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_dest  = '0;
    bus.req_data  = '0;
    bus.out_ready = '0;
    tick();
    test_reset();
    test_permutation();
    test_hotspot();
    test_fairness();
    test_backpressure();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
